// File: rtl/shift_add_multiplier_pkg.sv
// rtl/shift_add_multiplier_pkg.sv - shared types and helpers for the shift-and-add multiplier
package multiplier_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_t;

  // Step counter must be able to hold the value N itself.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// rtl/shift_add_multiplier_if.sv - operand/result bundle; done exists only with MULTIPLIER_DONE_PULSE_EN
interface shift_add_multiplier_if #(
  parameter int N = 4
);
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic [2*N-1:0] product;
  logic           ready;
`ifdef MULTIPLIER_DONE_PULSE_EN
  logic           done;
`endif

  modport master (
    output start, multiplicand, multiplier,
`ifdef MULTIPLIER_DONE_PULSE_EN
    input  done,
`endif
    input  product, ready
  );

  modport slave (
    input  start, multiplicand, multiplier,
`ifdef MULTIPLIER_DONE_PULSE_EN
    output done,
`endif
    output product, ready
  );

endinterface

// File: rtl/shift_add_multiplier_step.sv
// rtl/shift_add_multiplier_step.sv - one combinational add-and-shift step of the multiplier
module shift_add_step #(
  parameter int N = 4
) (
  input  logic [2*N-1:0] product_i,
  input  logic [N-1:0]   multiplicand_i,
  output logic [2*N-1:0] product_o
);

  logic [N:0]   upper_sum;
  logic [2*N:0] wide;

  // The carry out of the upper add becomes the new MSB after the shift.
  always_comb begin
    upper_sum = {1'b0, product_i[2*N-1:N]};
    if (product_i[0]) begin
      upper_sum = upper_sum + {1'b0, multiplicand_i};
    end
    wide      = {upper_sum, product_i[N-1:0]};
    product_o = wide[2*N:1];
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential N x N -> 2N multiplier; MULTIPLIER_DONE_PULSE_EN adds a done pulse
module shift_add_multiplier #(
  parameter int N = 4
) (
  input logic                  clock,
  input logic                  reset,
  shift_add_multiplier_if.slave bus
);
  import multiplier_pkg::*;

  localparam int CW = cnt_width(N);

  mult_state_t    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   mcand_q, mcand_d;
  logic [2*N-1:0] product_q, product_d;
  logic [2*N-1:0] step_product;
  logic           ready_q, ready_d;
`ifdef MULTIPLIER_DONE_PULSE_EN
  logic           done_q, done_d;
`endif

  shift_add_step #(.N(N)) u_step (
    .product_i      (product_q),
    .multiplicand_i (mcand_q),
    .product_o      (step_product)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    product_d = product_q;
    ready_d   = ready_q;
`ifdef MULTIPLIER_DONE_PULSE_EN
    done_d    = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          mcand_d   = bus.multiplicand;
          product_d = {{N{1'b0}}, bus.multiplier};
          cnt_d     = '0;
          ready_d   = 1'b0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        product_d = step_product;
        cnt_d     = cnt_q + CW'(1);
        // Last step completes the result on this same edge.
        if (cnt_q == CW'(N - 1)) begin
          ready_d = 1'b1;
          state_d = DONE;
`ifdef MULTIPLIER_DONE_PULSE_EN
          done_d  = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      product_q <= '0;
      ready_q   <= 1'b0;
`ifdef MULTIPLIER_DONE_PULSE_EN
      done_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      product_q <= product_d;
      ready_q   <= ready_d;
`ifdef MULTIPLIER_DONE_PULSE_EN
      done_q    <= done_d;
`endif
    end
  end

  assign bus.product = product_q;
  assign bus.ready   = ready_q;
`ifdef MULTIPLIER_DONE_PULSE_EN
  assign bus.done    = done_q;
`endif

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier
module tb_shift_add_multiplier;

  localparam int N = 4;

  logic clock;
  logic reset;

  int checks = 0;
  int errors = 0;

  shift_add_multiplier_if #(.N(N)) bus ();

  shift_add_multiplier #(.N(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // After k steps the upper bits hold A*(B mod 2^k) aligned at bit N-k and the
  // unconsumed multiplier bits B>>k sit below it.
  function automatic logic [2*N-1:0] partial(input int a, input int b, input int k);
    longint p;
    p = (longint'(a) * (longint'(b) & ((longint'(1) << k) - 1))) << (N - k);
    p = p + (longint'(b) >> k);
    return (2*N)'(p);
  endfunction

  logic [2*N-1:0] m_prod;
  logic           m_ready, m_done, m_busy, m_valid;
  int             m_a, m_b, m_k;

  initial begin
    m_valid = 1'b0;
    m_busy  = 1'b0;
    m_ready = 1'b0;
    m_done  = 1'b0;
    m_prod  = '0;
    m_k     = 0;
    m_a     = 0;
    m_b     = 0;
  end

  always @(posedge clock) begin
    m_done = 1'b0;
    if (reset) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_ready = 1'b0;
      m_k     = 0;
      m_prod  = '0;
    end else if (m_busy) begin
      m_k    = m_k + 1;
      m_prod = partial(m_a, m_b, m_k);
      if (m_k == N) begin
        m_busy  = 1'b0;
        m_ready = 1'b1;
        m_done  = 1'b1;
      end
    end else if (bus.start) begin
      m_a     = int'(bus.multiplicand);
      m_b     = int'(bus.multiplier);
      m_k     = 0;
      m_busy  = 1'b1;
      m_ready = 1'b0;
      m_prod  = partial(m_a, m_b, 0);
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      chk("model_product", 64'(bus.product), 64'(m_prod));
      chk("model_ready", 64'(bus.ready), 64'(m_ready));
`ifdef MULTIPLIER_DONE_PULSE_EN
      chk("model_done", 64'(bus.done), 64'(m_done));
`endif
    end
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic load(input int a, input int b);
    bus.start        = 1'b1;
    bus.multiplicand = N'(a);
    bus.multiplier   = N'(b);
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic run(input string name, input int a, input int b, input int exp);
    load(a, b);
    repeat (N) cyc();
    chk({name, "_product"}, 64'(bus.product), 64'(exp));
    chk({name, "_ready"}, 64'(bus.ready), 64'd1);
  endtask

  int trace [4] = '{3, 89, 132, 66};

  initial begin
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    cyc();
    cyc();
    chk("reset_product", 64'(bus.product), 64'd0);
    chk("reset_ready", 64'(bus.ready), 64'd0);
    reset = 1'b0;
    cyc();
    chk("idle_product", 64'(bus.product), 64'd0);
    chk("idle_ready", 64'(bus.ready), 64'd0);

    load(11, 6);
    chk("trace_load", 64'(bus.product), 64'd6);
    chk("trace_load_ready", 64'(bus.ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("trace_step%0d", i + 1), 64'(bus.product), 64'(trace[i]));
      chk($sformatf("trace_ready%0d", i + 1), 64'(bus.ready), 64'(i == 3));
    end

    run("carry_15x15", 15, 15, 225);
    run("zero_a", 0, 9, 0);
    run("zero_b", 7, 0, 0);

    load(11, 6);
    bus.start        = 1'b1;
    bus.multiplicand = 4'd2;
    bus.multiplier   = 4'd2;
    repeat (N - 1) cyc();
    bus.start = 1'b0;
    cyc();
    chk("busy_start_product", 64'(bus.product), 64'd66);
    chk("busy_start_ready", 64'(bus.ready), 64'd1);

    load(3, 5);
    chk("b2b_load_ready", 64'(bus.ready), 64'd0);
    repeat (N) cyc();
    chk("b2b_product", 64'(bus.product), 64'd15);

    bus.start        = 1'b1;
    bus.multiplicand = 4'd2;
    bus.multiplier   = 4'd3;
    repeat (N + 1) cyc();
    chk("hold_start_done", 64'(bus.product), 64'd6);
    chk("hold_start_ready", 64'(bus.ready), 64'd1);
    cyc();
    chk("hold_start_reload", 64'(bus.ready), 64'd0);
    bus.start = 1'b0;
    repeat (N) cyc();
    chk("hold_start_second", 64'(bus.product), 64'd6);

    load(11, 6);
    cyc();
    reset = 1'b1;
    cyc();
    chk("abort_product", 64'(bus.product), 64'd0);
    chk("abort_ready", 64'(bus.ready), 64'd0);
    reset = 1'b0;
    cyc();
    chk("abort_idle", 64'(bus.product), 64'd0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
